// File: rtl/mc_cr_sched_if.sv
// ---------------------------------------------------------------------------
// mc_cr_sched_if
// Bundle of every handshake/bus signal around the chroma MC residual
// sequencer: MB job request, mc_cr start handshake, mc_cr residual beat
// stream, and the registered tagged output beat stream.
//
// Modports
//   master : the sequencer (mc_cr_sched) view
//   slave  : the surrounding environment view (MB FSM, mc_cr, downstream)
//
// Handshake rule for every valid/ready pair below: a transfer happens on a
// rising clock edge where both valid and ready are 1; a source that raises
// valid keeps it (and its payload) stable until that edge.
//
// Signals
//   mb_valid / mb_ready / mb_tag      : job request, accept, MB identifier
//   mc_sel                            : 0 = Cb, 1 = Cr, selects mc_cr inputs
//   mc_src_valid / mc_src_ready       : start request to mc_cr
//   mc_dst_valid / mc_dst_ready/mc_res: residual beats from mc_cr {pix1,pix0}
//   out_valid / out_ready / out_data  : registered output beat
//   out_comp / out_beat / out_last    : component, beat index, end of MB
//   out_tag                           : captured mb_tag
// ---------------------------------------------------------------------------
interface mc_cr_sched_if #(
    parameter int MB_SIZE     = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int TAG_W       = 16
);
    localparam int BEATS  = MB_SIZE * MB_SIZE / 2;
    localparam int BEAT_W = $clog2(BEATS);

    logic                     mb_valid;
    logic                     mb_ready;
    logic [TAG_W-1:0]         mb_tag;

    logic                     mc_sel;
    logic                     mc_src_valid;
    logic                     mc_src_ready;
    logic                     mc_dst_valid;
    logic                     mc_dst_ready;
    logic [2*PIXEL_WIDTH-1:0] mc_res;

    logic                     out_valid;
    logic                     out_ready;
    logic [2*PIXEL_WIDTH-1:0] out_data;
    logic                     out_comp;
    logic [BEAT_W-1:0]        out_beat;
    logic                     out_last;
    logic [TAG_W-1:0]         out_tag;

    modport master (
        input  mb_valid, mb_tag, mc_src_ready, mc_dst_valid, mc_res, out_ready,
        output mb_ready, mc_sel, mc_src_valid, mc_dst_ready,
        output out_valid, out_data, out_comp, out_beat, out_last, out_tag
    );

    modport slave (
        output mb_valid, mb_tag, mc_src_ready, mc_dst_valid, mc_res, out_ready,
        input  mb_ready, mc_sel, mc_src_valid, mc_dst_ready,
        input  out_valid, out_data, out_comp, out_beat, out_last, out_tag
    );
endinterface

// File: rtl/mc_cr_sched.sv
// ---------------------------------------------------------------------------
// mc_cr_sched
// Sequencer for the single shared chroma MC residual unit (mc_cr). Accepts
// one macroblock job, starts mc_cr for Cb and then Cr, and drains BEATS
// residual beats per component through a single registered output stage,
// tagging each beat with component, beat index and MB tag.
//
// Optional feature: define MC_CR_SCHED_PERF_EN to build the saturating
// output-stall and completed-MB counters; otherwise both read as 0.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-low
//   bus          : mc_cr_sched_if.master (job, mc_cr and output handshakes)
//   o_busy       : FSM not in IDLE
//   o_done       : one-cycle pulse at MB completion
//   o_perf_stall : cycles with out_valid & !out_ready (optional feature)
//   o_perf_mbs   : completed MB count (optional feature)
//   o_dbg_state  : current FSM state encoding
// ---------------------------------------------------------------------------
module mc_cr_sched #(
    parameter int MB_SIZE     = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int TAG_W       = 16
) (
    input  logic          clk,
    input  logic          reset,
    mc_cr_sched_if.master bus,
    output logic          o_busy,
    output logic          o_done,
    output logic [31:0]   o_perf_stall,
    output logic [31:0]   o_perf_mbs,
    output logic [2:0]    o_dbg_state
);
    localparam int BEATS  = MB_SIZE * MB_SIZE / 2;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_CB = 3'd1,
        S_DRAIN_CB = 3'd2,
        S_ISSUE_CR = 3'd3,
        S_DRAIN_CR = 3'd4,
        S_FLUSH    = 3'd5
    } state_t;

    state_t                   r_state;
    logic [BEAT_W-1:0]        r_beat;
    logic                     r_mb_ready;
    logic                     r_mc_sel;
    logic                     r_src_valid;
    logic                     r_done;
    logic [TAG_W-1:0]         r_tag;

    logic                     r_out_valid;
    logic [2*PIXEL_WIDTH-1:0] r_out_data;
    logic                     r_out_comp;
    logic [BEAT_W-1:0]        r_out_beat;
    logic                     r_out_last;
    logic [TAG_W-1:0]         r_out_tag;

    logic w_in_drain;
    logic w_dst_ready;
    logic w_dst_fire;
    logic w_out_fire;
    logic w_last_beat;

    assign w_in_drain  = (r_state == S_DRAIN_CB) || (r_state == S_DRAIN_CR);
    // Single output register with no skid: accept a new beat only when the
    // register is empty or is being emptied on this same edge.
    assign w_dst_ready = w_in_drain && (!r_out_valid || bus.out_ready);
    assign w_dst_fire  = w_dst_ready && bus.mc_dst_valid;
    assign w_out_fire  = r_out_valid && bus.out_ready;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

    // Control FSM. mb_ready is held low in the done cycle so the next job can
    // only be accepted one cycle after returning to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_mb_ready  <= 1'b1;
            r_mc_sel    <= 1'b0;
            r_src_valid <= 1'b0;
            r_done      <= 1'b0;
            r_tag       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_mb_ready) begin
                        r_mb_ready <= 1'b1;
                    end else if (bus.mb_valid) begin
                        r_tag       <= bus.mb_tag;
                        r_mb_ready  <= 1'b0;
                        r_mc_sel    <= 1'b0;
                        r_src_valid <= 1'b1;
                        r_state     <= S_ISSUE_CB;
                    end
                end
                S_ISSUE_CB: begin
                    if (bus.mc_src_ready) begin
                        r_src_valid <= 1'b0;
                        r_state     <= S_DRAIN_CB;
                    end
                end
                S_DRAIN_CB: begin
                    if (w_dst_fire) begin
                        if (w_last_beat) begin
                            r_beat      <= '0;
                            r_mc_sel    <= 1'b1;
                            r_src_valid <= 1'b1;
                            r_state     <= S_ISSUE_CR;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_ISSUE_CR: begin
                    if (bus.mc_src_ready) begin
                        r_src_valid <= 1'b0;
                        r_state     <= S_DRAIN_CR;
                    end
                end
                S_DRAIN_CR: begin
                    if (w_dst_fire) begin
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= S_FLUSH;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Finish once the final beat is gone or leaves on this edge.
                    if (!r_out_valid || bus.out_ready) begin
                        r_done   <= 1'b1;
                        r_mc_sel <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: load wins over drain so load+drain in one cycle keeps
    // one beat per cycle; fields only change on a load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_comp  <= 1'b0;
            r_out_beat  <= '0;
            r_out_last  <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_dst_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.mc_res;
            r_out_comp  <= r_mc_sel;
            r_out_beat  <= r_beat;
            r_out_last  <= r_mc_sel && w_last_beat;
            r_out_tag   <= r_tag;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MC_CR_SCHED_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_mbs;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_stall <= '0;
            r_perf_mbs   <= '0;
        end else begin
            if (r_out_valid && !bus.out_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (r_done && (r_perf_mbs != 32'hFFFF_FFFF)) begin
                r_perf_mbs <= r_perf_mbs + 32'd1;
            end
        end
    end

    assign o_perf_stall = r_perf_stall;
    assign o_perf_mbs   = r_perf_mbs;
`else
    assign o_perf_stall = 32'd0;
    assign o_perf_mbs   = 32'd0;
`endif

    assign bus.mb_ready     = r_mb_ready;
    assign bus.mc_sel       = r_mc_sel;
    assign bus.mc_src_valid = r_src_valid;
    assign bus.mc_dst_ready = w_dst_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_comp     = r_out_comp;
    assign bus.out_beat     = r_out_beat;
    assign bus.out_last     = r_out_last;
    assign bus.out_tag      = r_out_tag;

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: doc/mc_cr_sched.md
Name: mc_cr_sched

Overview:
Sequencer for the single shared chroma motion-compensation residual unit (mc_cr, 8x8 block, 2 pixels per output beat).
- Accepts one macroblock job and issues Cb then Cr to mc_cr.
- Drains 32 residual beats per component through a registered output stage, tagging each beat with component, beat index and MB tag.
- Sits between the MB-level control FSM and the chroma transform/quant input.

Parameters:
MB_SIZE, 8, chroma block edge in pixels
PIXEL_WIDTH, 8, bits per residual pixel
TAG_W, 16, width of macroblock tag
BEATS, MB_SIZE*MB_SIZE/2, beats per component (derived, localparam)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low (0 = reset)
mb_valid  in  1  job request
mb_ready  out  1  job accept; high only in IDLE
mb_tag  in  TAG_W  MB identifier, captured on accept
mc_sel  out  1  0=Cb, 1=Cr; drives external ref/curr mux into mc_cr
mc_src_valid  out  1  start request to mc_cr
mc_src_ready  in  1  mc_cr accepts start
mc_dst_valid  in  1  mc_cr residual beat valid
mc_dst_ready  out  1  back-pressure to mc_cr
mc_res  in  2*PIXEL_WIDTH  residual beat {pix1,pix0}
out_valid  out  1  registered beat valid
out_ready  in  1  downstream ready
out_data  out  2*PIXEL_WIDTH  residual beat
out_comp  out  1  component of beat
out_beat  out  $clog2(BEATS)  beat index 0..BEATS-1
out_last  out  1  last beat of Cr (end of MB)
out_tag  out  TAG_W  captured mb_tag
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at MB completion
perf_stall  out  32  output stall cycle count (optional feature)
perf_mbs  out  32  completed MB count (optional feature)

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, beat counter=0.
  - All outputs 0 except mb_ready=1.
  - Output register emptied (out_valid=0); perf counters cleared.
  - Reset mid-operation abandons the job; in-flight beats are dropped.
- States: IDLE -> ISSUE_CB -> DRAIN_CB -> ISSUE_CR -> DRAIN_CR -> FLUSH -> IDLE.
- IDLE: mb_ready=1. On mb_valid: capture mb_tag, go to ISSUE_CB.
- ISSUE_x:
  - mc_src_valid=1, mc_sel=component.
  - Hold until the cycle with mc_src_ready=1, then go to DRAIN_x.
  - mc_src_valid drops the cycle after acceptance.
- DRAIN_x:
  - mc_dst_ready = !out_valid | out_ready (skid-free single register).
  - On mc_dst_valid & mc_dst_ready, load the output register with data, comp, beat, tag; increment beat counter.
  - out_last = (comp==Cr && beat==BEATS-1).
  - Accepting beat BEATS-1: counter wraps to 0, state advances (DRAIN_CB -> ISSUE_CR, DRAIN_CR -> FLUSH).
- mc_sel holds its value through ISSUE and DRAIN of a component.
- Outside DRAIN states: mc_dst_ready=0; mc_dst_valid is ignored (no count, no load).
- Output register:
  - Latency 1 cycle from accepted mc_dst beat to out_valid.
  - Cleared when out_ready & out_valid and no new load that cycle.
  - Load and drain in the same cycle are allowed: full throughput, 1 beat/cycle.
  - Output fields hold stable while out_valid & !out_ready.
- FLUSH: wait until the output register is empty or draining (out_valid==0, or out_valid & out_ready). Then pulse done=1 for one cycle and return to IDLE.
- mb_ready is not asserted in the done cycle; the next job is accepted at the earliest the cycle after return to IDLE.
- A new mb_valid while busy is not accepted.
- Minimum MB time (no stalls, mc_src_ready immediate) = 1 + 1 + 32 + 1 + 32 + 1 cycles.

Optional Feature:
MC_CR_SCHED_PERF_EN defined:
- perf_stall increments every cycle with out_valid & !out_ready.
- perf_mbs increments on each done pulse.
- Both saturate at 2^32-1; both cleared by reset.

Not defined: perf_stall and perf_mbs are tied to 0 and no counter logic is built.

Test Plan:
- Basic MB: reset low 2 cycles, mb_tag=0x0012, mc_src_ready=1, mc_dst_valid=1 continuous, out_ready=1 -> 64 beats.
  - First 32 with out_comp=0, beats 0..31; next 32 with out_comp=1.
  - out_last only on Cr beat 31; out_tag=0x0012 on all beats.
  - done one pulse after the final beat; mb_ready=1 afterward.
- Back-pressure: out_ready toggling 1/0 each cycle -> no beat lost or duplicated.
  - out_data equals the mc_res sequence 0x0100,0x0302,... in order.
  - Fields stable while stalled.
  - Perf build: perf_stall = number of stall cycles.
- Start handshake: mc_src_ready held 0 for 5 cycles -> mc_src_valid held high with mc_sel=0 for those cycles, mc_dst_ready=0 throughout, then DRAIN_CB.
- Spurious input: mc_dst_valid=1 in IDLE and ISSUE_CR -> mc_dst_ready=0, no out_valid, beat counter unchanged.
- Reset mid-operation: reset=0 at Cb beat 10 -> next cycle state IDLE, out_valid=0, mb_ready=1. A new job restarts with beat 0, comp 0.
- Back-to-back: mb_valid held high for 3 jobs, tags 1,2,3 -> three done pulses, perf_mbs=3, each job's beats tagged correctly, no overlap between jobs.
